// File: rtl/button_pulse_generator.sv
// Push-button conditioner: 2-flop sync, per-bit debounce, press-edge detect and
// priority serializer giving one active-low pulse per press. BTN_AUTOREPEAT_EN adds auto-repeat.
module button_pulse_generator #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rawBtn,
  output logic [3:0] outBtn,
  output logic [3:0] btnLevel
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParam
    $error("button_pulse_generator: illegal parameter value");
  end

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    st;
  logic [3:0]    stD;
  logic [CW-1:0] cnt [4];
  logic [3:0]    pend;
  logic [3:0]    pressEv;
  logic [3:0]    repReq;
  logic [3:0]    pendNext;
  logic [3:0]    grant;
  logic [1:0]    grantIdx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= rawBtn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= '1;
      stD <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stD <= st;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          st[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign btnLevel = st;
  assign pressEv  = stD & ~st;

  always_comb begin
    pendNext = pend | pressEv | repReq;
    grant    = '0;
    grantIdx = '0;
    if (pendNext[3]) begin
      grant    = 4'b1000;
      grantIdx = 2'd3;
    end else if (pendNext[2]) begin
      grant    = 4'b0100;
      grantIdx = 2'd2;
    end else if (pendNext[1]) begin
      grant    = 4'b0010;
      grantIdx = 2'd1;
    end else if (pendNext[0]) begin
      grant    = 4'b0001;
      grantIdx = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend   <= '0;
      outBtn <= '1;
    end else begin
      pend   <= pendNext & ~grant;
      outBtn <= ~grant;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] repCnt;
  logic [1:0]    owner;
  logic          repActive;
  logic [3:0]    realPend;
  logic [3:0]    realNext;

  // realPend tracks which pending bits came from an actual press, so that
  // emitting a repeat pulse does not restart the initial repeat delay.
  always_comb begin
    realNext = realPend | pressEv;
    repReq   = '0;
    if (repActive && !st[owner] && repCnt == '0) begin
      repReq[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      repCnt    <= '0;
      owner     <= '0;
      repActive <= 1'b0;
      realPend  <= '0;
    end else begin
      realPend <= realNext & ~grant;
      if (|(grant & realNext)) begin
        owner     <= grantIdx;
        repCnt    <= RW'(REPEAT_DELAY - 1);
        repActive <= 1'b1;
      end else if (repActive) begin
        if (st[owner]) begin
          repActive <= 1'b0;
        end else if (repCnt == '0) begin
          repCnt <= RW'(REPEAT_PERIOD - 1);
        end else begin
          repCnt <= repCnt - RW'(1);
        end
      end
    end
  end
`else
  assign repReq = '0;
`endif

endmodule

// File: tb/tb_button_pulse_generator.sv
// Scoreboard bench for button_pulse_generator (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
module tb_button_pulse_generator;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rawBtn;
  logic [3:0] outBtn;
  logic [3:0] btnLevel;

  always #5 clk = ~clk;

  button_pulse_generator #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rawBtn(rawBtn),
    .outBtn(outBtn),
    .btnLevel(btnLevel)
  );

  typedef struct {
    int         at;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle outBtn must equal the scheduled pulse or idle.
  always @(negedge clk) begin
    logic [3:0] want;
    want = 4'b1111;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      want = sb[0].v;
      void'(sb.pop_front());
    end
    chk(want == 4'b1111 ? "outIdle" : "outPulse", {28'd0, outBtn}, {28'd0, want});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Schedule the pulses for pattern pat first sampled on edge d+1 and released at d+h.
  task automatic pushPress(input logic [3:0] pat, input int d, input int h);
    exp_t e;
    int   k;
    k = 0;
    for (int b = 3; b >= 0; b--) begin
      if (!pat[b]) begin
        e.at = d + DEB + 3 + k;
        e.v  = 4'b1111;
        e.v[b] = 1'b0;
        sb.push_back(e);
        k++;
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    if (k > 0) begin
      for (int t = d + DEB + 3 + k - 1 + RD; t <= d + h + DEB + 2; t += RP) begin
        e.at = t;
        sb.push_back(e);
      end
    end
`endif
  endtask

  task automatic pressRelease(input logic [3:0] pat, input int h, input int tail);
    int d;
    d = cyc;
    rawBtn = pat;
    pushPress(pat, d, h);
    step(h);
    rawBtn = 4'b1111;
    step(tail);
  endtask

  initial begin
    int   d;
    exp_t e;

    reset  = 1'b0;
    rawBtn = 4'b0000;
    step(4);
    chk("lvlInReset", {28'd0, btnLevel}, 32'hF);
    chk("outInReset", {28'd0, outBtn}, 32'hF);

    // Reset release with up held: must debounce from idle.
    d = cyc;
    rawBtn = 4'b0111;
    reset  = 1'b1;
    pushPress(4'b0111, d, 12);
    step(5);
    chk("lvlBeforeFlip", {28'd0, btnLevel}, 32'hF);
    step(1);
    chk("lvlAfterFlip", {28'd0, btnLevel}, 32'h7);
    step(6);
    rawBtn = 4'b1111;
    step(12);
    chk("lvlReleased", {28'd0, btnLevel}, 32'hF);

    // Single press held 20 cycles.
    d = cyc;
    rawBtn = 4'b0111;
    pushPress(4'b0111, d, 20);
    step(5);
    chk("lvlSingPre", {28'd0, btnLevel}, 32'hF);
    step(1);
    chk("lvlSingPost", {28'd0, btnLevel}, 32'h7);
    step(14);
    rawBtn = 4'b1111;
    step(12);

    // Glitch shorter than the debounce window.
    rawBtn = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("lvlGlitch", {28'd0, btnLevel}, 32'hF);
    end
    rawBtn = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("lvlGlitchAfter", {28'd0, btnLevel}, 32'hF);
    end

    // Exactly DEBOUNCE_CYCLES low samples is enough.
    pressRelease(4'b1110, DEB, 12);

    // Simultaneous up+right.
    pressRelease(4'b0110, 5, 12);

    // Bouncing left, then stable.
    for (int i = 0; i < 10; i++) begin
      rawBtn = (i % 2 == 0) ? 4'b1101 : 4'b1111;
      step(1);
    end
    pressRelease(4'b1101, 5, 12);

    // Async reset during a pulse, with a second press still pending.
    d = cyc;
    rawBtn = 4'b0110;
    e.at = d + DEB + 3;
    e.v  = 4'b0111;
    sb.push_back(e);
    step(DEB + 3);
    chk("pulseLive", {28'd0, outBtn}, 32'h7);
    #4;
    reset = 1'b0;
    #1;
    chk("asyncOut", {28'd0, outBtn}, 32'hF);
    chk("asyncLvl", {28'd0, btnLevel}, 32'hF);
    step(3);
    d = cyc;
    reset = 1'b1;
    pushPress(4'b0110, d, 8);
    step(8);
    rawBtn = 4'b1111;
    step(12);

    // Partially counted press discarded by reset.
    rawBtn = 4'b1110;
    step(3);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("lvlPartial", {28'd0, btnLevel}, 32'hF);
    end
    rawBtn = 4'b1111;
    step(12);
    chk("lvlPartialEnd", {28'd0, btnLevel}, 32'hF);

`ifdef BTN_AUTOREPEAT_EN
    pressRelease(4'b1011, 30, 14);
`endif

    step(2);
    chk("sbEmpty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
